// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction-fetch stage. Owns the PC, drives the instruction-
//            memory request interface and the IF/ID pipeline register.
//            Applies the hazard-unit stall controls and the ID-stage branch
//            redirect, absorbs imem wait states, and parks a fetched word
//            while IF/ID is frozen.
// Ports    : clk_i, rst_n (async, active-low)
//            PC_Write, IF_ID_write      - hazard-unit stall controls
//            Branch_taken, Branch_target- ID-stage redirect
//            imem_req/addr/ready/rdata  - instruction-memory handshake
//            IF_ID_pc/pc_plus4/instr/valid - IF/ID pipeline register
//            fetch_stall                - bubble caused by memory or redirect
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IF_ID_write,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc_plus4,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] c_pc_inc    = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_nxt;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic        w_load;        // load IF/ID with w_word
    logic        w_bubble;      // insert a bubble into IF/ID
    logic [31:0] w_word;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_stall;

    assign w_pc_plus4 = r_pc + c_pc_inc;        // wraps modulo 2^32
    assign w_target   = Branch_target & c_word_mask;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pending_nxt = r_pending_pc;
        w_hold_nxt    = r_hold_instr;
        w_load        = 1'b0;
        w_bubble      = 1'b0;
        w_word        = imem_rdata;
        w_req         = 1'b0;
        w_stall       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (Branch_taken) begin
                    w_pc_nxt = w_target;
                    w_bubble = 1'b1;
                    w_stall  = 1'b1;
                end
            end

            S_FETCH: begin
                w_req = 1'b1;
                if (Branch_taken) begin
                    w_bubble = 1'b1;
                    w_stall  = 1'b1;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // The access to the old PC must finish before the
                        // address can move, so park the target.
                        w_pending_nxt = w_target;
                        w_state_nxt   = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    if (IF_ID_write) begin
                        w_load = 1'b1;
                        if (PC_Write) begin
                            w_pc_nxt = w_pc_plus4;
                        end
                    end else begin
                        // Word arrived while IF/ID is frozen: keep it so the
                        // same address is never fetched twice.
                        w_hold_nxt  = imem_rdata;
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = IF_ID_write;
                end
            end

            S_HOLD: begin
                w_word = r_hold_instr;
                if (Branch_taken) begin
                    w_bubble    = 1'b1;
                    w_stall     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (IF_ID_write) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_FETCH;
                    if (PC_Write) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end

            S_DRAIN: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                w_bubble = Branch_taken | IF_ID_write;
                if (Branch_taken) begin
                    w_pending_nxt = w_target;
                end
                if (imem_ready) begin
                    // A redirect arriving on the completion cycle is the
                    // latest one and wins over the parked target.
                    w_pc_nxt    = Branch_taken ? w_target : r_pending_pc;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_pc             <= RESET_PC & c_word_mask;
            r_pending_pc     <= 32'd0;
            r_hold_instr     <= 32'd0;
            r_if_id_pc       <= 32'd0;
            r_if_id_pc_plus4 <= 32'd0;
            r_if_id_instr    <= 32'd0;
            r_if_id_valid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending_pc <= w_pending_nxt;
            r_hold_instr <= w_hold_nxt;
            if (w_load) begin
                r_if_id_pc       <= r_pc;
                r_if_id_pc_plus4 <= w_pc_plus4;
                r_if_id_instr    <= w_word;
                r_if_id_valid    <= 1'b1;
            end else if (w_bubble) begin
                r_if_id_instr <= 32'd0;
                r_if_id_valid <= 1'b0;
            end
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign fetch_stall    = w_stall;
    assign IF_ID_pc       = r_if_id_pc;
    assign IF_ID_pc_plus4 = r_if_id_pc_plus4;
    assign IF_ID_instr    = r_if_id_instr;
    assign IF_ID_valid    = r_if_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Directed self-checking bench for if_fetch_stage. Edge numbers
//            in comments count rising edges after reset release (edge 1 is
//            the IDLE->FETCH edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] c_mix = 32'h1357_9BDF;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        PC_Write;
    logic        IF_ID_write;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        fetch_stall;

    int total = 0;
    int bad   = 0;
    int acc8  = 0;
    int acc8_start;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .PC_Write       (PC_Write),
        .IF_ID_write    (IF_ID_write),
        .Branch_taken   (Branch_taken),
        .Branch_target  (Branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_valid    (IF_ID_valid),
        .fetch_stall    (fetch_stall)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: each word is a fixed function of its address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ c_mix;
    endfunction

    assign imem_rdata = mem(imem_addr);

    // Completed accesses to address 0x8.
    always @(posedge clk_i) begin
        if (imem_req && imem_ready && imem_addr == 32'h8) acc8 <= acc8 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reset, release, and run three edges: IF/ID holds 0x4, PC = 0x8.
    task automatic boot();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        PC_Write      = 1'b1;
        IF_ID_write   = 1'b1;
        Branch_taken  = 1'b0;
        Branch_target = 32'h0;
        imem_ready    = 1'b1;
        tick();
        tick();

        // ---- reset state ----
        check("rst_req",    {31'd0, imem_req},    32'd0);
        check("rst_pc",     IF_ID_pc,             32'd0);
        check("rst_plus4",  IF_ID_pc_plus4,       32'd0);
        check("rst_instr",  IF_ID_instr,          32'd0);
        check("rst_valid",  {31'd0, IF_ID_valid}, 32'd0);
        check("rst_stall",  {31'd0, fetch_stall}, 32'd0);

        // ---- startup, ready tied high ----
        rst_n = 1'b1;
        tick();                                             // edge 1
        check("e1_req",   {31'd0, imem_req},    32'd1);
        check("e1_addr",  imem_addr,            32'h0);
        check("e1_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick();                                             // edge 2
        check("e2_pc",    IF_ID_pc,             32'h0);
        check("e2_plus4", IF_ID_pc_plus4,       32'h4);
        check("e2_instr", IF_ID_instr,          32'h1357_9BDF);
        check("e2_valid", {31'd0, IF_ID_valid}, 32'd1);
        tick();                                             // edge 3
        check("e3_pc",    IF_ID_pc,             32'h4);
        check("e3_instr", IF_ID_instr,          32'h1357_9BDB);
        tick();                                             // edge 4
        check("e4_pc",    IF_ID_pc,             32'h8);
        check("e4_instr", IF_ID_instr,          32'h1357_9BD7);

        // ---- two imem wait cycles at PC=0x8 ----
        boot();
        check("w_start_pc", IF_ID_pc, 32'h4);
        imem_ready = 1'b0;
        #1;
        check("w_addr0",  imem_addr,            32'h8);
        check("w_req0",   {31'd0, imem_req},    32'd1);
        check("w_stall0", {31'd0, fetch_stall}, 32'd1);
        tick();
        check("w_valid1", {31'd0, IF_ID_valid}, 32'd0);
        check("w_instr1", IF_ID_instr,          32'd0);
        check("w_pc1",    IF_ID_pc,             32'h4);
        check("w_addr1",  imem_addr,            32'h8);
        check("w_stall1", {31'd0, fetch_stall}, 32'd1);
        tick();
        check("w_valid2", {31'd0, IF_ID_valid}, 32'd0);
        check("w_addr2",  imem_addr,            32'h8);
        imem_ready = 1'b1;
        #1;
        check("w_stall_off", {31'd0, fetch_stall}, 32'd0);
        tick();
        check("w_pc3",    IF_ID_pc,             32'h8);
        check("w_valid3", {31'd0, IF_ID_valid}, 32'd1);
        check("w_instr3", IF_ID_instr,          32'h1357_9BD7);

        // ---- load-use stall while fetching 0x8 ----
        boot();
        acc8_start  = acc8;
        PC_Write    = 1'b0;
        IF_ID_write = 1'b0;
        tick();                                             // -> HOLD
        check("h_pc",    IF_ID_pc,             32'h4);
        check("h_instr", IF_ID_instr,          32'h1357_9BDB);
        check("h_valid", {31'd0, IF_ID_valid}, 32'd1);
        check("h_req",   {31'd0, imem_req},    32'd0);
        check("h_stall", {31'd0, fetch_stall}, 32'd0);
        PC_Write    = 1'b1;
        IF_ID_write = 1'b1;
        tick();
        check("h_pc8",    IF_ID_pc,    32'h8);
        check("h_instr8", IF_ID_instr, 32'h1357_9BD7);
        check("h_addrC",  imem_addr,   32'hC);

        // ---- taken branch to 0x41 while fetching 0xC ----
        Branch_taken  = 1'b1;
        Branch_target = 32'h41;
        #1;
        check("b_stall", {31'd0, fetch_stall}, 32'd1);
        tick();
        check("b_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("b_instr", IF_ID_instr,          32'd0);
        check("b_pc",    IF_ID_pc,             32'h8);
        check("b_addr",  imem_addr,            32'h40);
        Branch_taken = 1'b0;
        tick();
        check("b_pc40",    IF_ID_pc,       32'h40);
        check("b_plus4",   IF_ID_pc_plus4, 32'h44);
        check("b_instr40", IF_ID_instr,    32'h1357_9B9F);
        check("h_acc8",    acc8 - acc8_start, 32'd1);

        // ---- branch during pending access, re-redirect in DRAIN ----
        imem_ready    = 1'b0;
        Branch_taken  = 1'b1;
        Branch_target = 32'h40;
        #1;
        check("d_addr0",  imem_addr,            32'h44);
        check("d_stall0", {31'd0, fetch_stall}, 32'd1);
        tick();                                             // -> DRAIN
        check("d_valid1", {31'd0, IF_ID_valid}, 32'd0);
        check("d_addr1",  imem_addr,            32'h44);
        check("d_req1",   {31'd0, imem_req},    32'd1);
        Branch_target = 32'h80;
        tick();
        check("d_valid2", {31'd0, IF_ID_valid}, 32'd0);
        check("d_addr2",  imem_addr,            32'h44);
        Branch_taken = 1'b0;
        tick();
        check("d_valid3", {31'd0, IF_ID_valid}, 32'd0);
        imem_ready = 1'b1;
        tick();                                             // old word discarded
        check("d_valid4", {31'd0, IF_ID_valid}, 32'd0);
        check("d_instr4", IF_ID_instr,          32'd0);
        check("d_addr4",  imem_addr,            32'h80);
        tick();
        check("d_pc80",    IF_ID_pc,             32'h80);
        check("d_instr80", IF_ID_instr,          32'h1357_9B5F);
        check("d_valid80", {31'd0, IF_ID_valid}, 32'd1);

        // ---- asynchronous reset mid-DRAIN ----
        imem_ready    = 1'b0;
        Branch_taken  = 1'b1;
        Branch_target = 32'h100;
        tick();                                             // -> DRAIN
        check("r_req_drain", {31'd0, imem_req}, 32'd1);
        Branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("r_req",   {31'd0, imem_req},    32'd0);
        check("r_pc",    IF_ID_pc,             32'd0);
        check("r_plus4", IF_ID_pc_plus4,       32'd0);
        check("r_instr", IF_ID_instr,          32'd0);
        check("r_valid", {31'd0, IF_ID_valid}, 32'd0);
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        tick();                                             // edge 1
        check("r_e1_addr", imem_addr,         32'h0);
        check("r_e1_req",  {31'd0, imem_req}, 32'd1);
        tick();                                             // edge 2
        check("r_e2_pc",    IF_ID_pc,             32'h0);
        check("r_e2_valid", {31'd0, IF_ID_valid}, 32'd1);

        // ---- PC+4 wraps at the top of the address space ----
        Branch_taken  = 1'b1;
        Branch_target = 32'hFFFF_FFFF;
        tick();
        check("x_addr", imem_addr, 32'hFFFF_FFFC);
        Branch_taken = 1'b0;
        tick();
        check("x_pc",    IF_ID_pc,       32'hFFFF_FFFC);
        check("x_plus4", IF_ID_pc_plus4, 32'h0);
        check("x_instr", IF_ID_instr,    32'hECA8_6423);
        check("x_addr0", imem_addr,      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
